serial_add_ctrl: RTL

- Bit-serial adder controller: sequences one full-adder cell, built from two half-adder datapath instances plus a carry OR, over a WIDTH-bit operand pair.
- Processes one bit per cycle, LSB first, with a start/busy/done handshake.
- Sits between a requester (e.g. an accumulator or test sequencer) and the shared 1-bit add datapath, trading latency for area.

---
 rtl/serial_add_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders) walked LSB first.
// Optional SERIAL_SUB_EN adds a sub input for (a - b) using the same cell.
module serial_add_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             s1;
    logic             c1;
    logic             s;
    logic             c2;
    logic             c_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    serial_add_ha u_ha1 (
        .x(ra[0]),
        .y(rb[0]),
        .s(s1),
        .c(c1)
    );

    serial_add_ha u_ha2 (
        .x(s1),
        .y(c),
        .s(s),
        .c(c2)
    );

    assign c_next = c1 | c2;

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in to 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            ra   <= a;
            rb   <= b_load;
            c    <= c_load;
            cnt  <= '0;
            cout <= 1'b0;
        end else if (state == RUN) begin
            ra  <= {1'b0, ra[WIDTH-1:1]};
            rb  <= {1'b0, rb[WIDTH-1:1]};
            c   <= c_next;
            cnt <= cnt + 1'b1;
            // Each result bit enters at the MSB; after WIDTH shifts it is aligned.
            sum <= {s, sum[WIDTH-1:1]};
            if (last) begin
                cout <= c_next;
            end
        end
    end
endmodule
